// File: rtl/load_store_unit.sv
// Memory-access stage: turns ALU results into data-memory loads/stores or
// passes them straight to writeback, stalling the pipeline while memory is busy.
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t              r_state;
  logic                r_ready;
  logic                r_stall;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_wb_valid;
  logic [REG_W-1:0]    r_wb_rd;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_misalign;
  logic [REG_W-1:0]    r_pend_rd;

  logic                w_accept;
  logic                w_is_mem;
  logic                w_aligned;

  assign w_accept  = ex_valid && r_ready;
  assign w_is_mem  = ex_memread || ex_memwrite;
  assign w_aligned = (ex_addr[1:0] == 2'b00);

  // Ready and stall are kept as separate registers so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_stall     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_misalign  <= 1'b0;
      r_pend_rd   <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= ex_addr;
              r_wb_rd    <= ex_rd;
            end else if (!w_aligned) begin
              r_misalign <= 1'b1;
            end else begin
              r_state     <= REQ;
              r_ready     <= 1'b0;
              r_stall     <= 1'b1;
              r_mem_req   <= 1'b1;
              r_mem_we    <= ex_memwrite;
              r_mem_addr  <= ex_addr;
              r_mem_wdata <= ex_wdata;
              r_pend_rd   <= ex_rd;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            // A read that is granted and answered in one cycle skips WAIT_R.
            if (r_mem_we || mem_rvalid) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_stall <= 1'b0;
              if (!r_mem_we) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= mem_rdata;
                r_wb_rd    <= r_pend_rd;
              end
            end else begin
              r_state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_stall    <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_data  <= mem_rdata;
            r_wb_rd    <= r_pend_rd;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign ex_ready  = r_ready;
  assign stall     = r_stall;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign misalign  = r_misalign;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the integer ALU in the CPU pipeline.
- Consumes the ALU result either as a byte address for loads and stores, or as a plain result for non-memory ops.
- Drives a single-port data-memory request/grant/response interface and produces the writeback value, register tag and a pipeline stall.
- Loads and stores are multi-cycle, handled by a small FSM. Non-memory ops pass straight through with 1-cycle latency.

Parameters:
- DATA_W, 32, data and address width.
- REG_W, 5, destination register index width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  execute stage presents an op
- ex_ready  output  1  LSU can accept an op this cycle
- ex_memread  input  1  op is a load
- ex_memwrite  input  1  op is a store
- ex_addr  input  DATA_W  ALU result: byte address for memory ops, result value otherwise
- ex_wdata  input  DATA_W  store data
- ex_rd  input  REG_W  destination register
- mem_req  output  1  memory request valid
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  DATA_W  byte address
- mem_wdata  output  DATA_W  write data
- mem_gnt  input  1  memory accepts the request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  DATA_W  read data
- wb_valid  output  1  one-cycle writeback pulse
- wb_rd  output  REG_W  writeback register
- wb_data  output  DATA_W  writeback value
- stall  output  1  equals ~ex_ready
- misalign  output  1  one-cycle pulse when a memory op is rejected

Behaviour:
- Reset:
  - All outputs are registered.
  - On reset (synchronous, active-high): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; wb_valid=0, wb_rd=0, wb_data=0; misalign=0.
  - ex_ready=1 in the first cycle after reset.
- States:
  - IDLE: ex_ready=1.
  - REQ: mem_req=1; mem_addr, mem_we and mem_wdata held stable.
  - WAIT_R: waiting for mem_rvalid.
  - ex_ready=0 in REQ and WAIT_R.
- Accept: an op is accepted on a cycle with ex_valid && ex_ready. All ex_* fields are sampled that cycle.
- Non-memory op (memread=0, memwrite=0):
  - Next cycle: wb_valid=1, wb_data=ex_addr, wb_rd=ex_rd.
  - Stays IDLE, so back-to-back ops are accepted every cycle.
- Memory op with ex_addr[1:0]!=0:
  - No memory request is issued.
  - Next cycle: misalign=1 for one cycle, wb_valid=0, state stays IDLE.
- Store (memwrite=1; takes priority if memread is also 1):
  - Next cycle: REQ with mem_we=1.
  - Remains in REQ until mem_gnt=1; the cycle after grant: IDLE, mem_req=0.
  - No wb_valid for stores.
- Load:
  - Next cycle: REQ with mem_we=0.
  - On mem_gnt: go to WAIT_R.
  - In WAIT_R, on mem_rvalid: next cycle wb_valid=1, wb_data=mem_rdata, wb_rd=latched rd, state=IDLE.
  - mem_gnt and mem_rvalid in the same REQ cycle: skip WAIT_R; the next cycle is the writeback cycle and IDLE.
- Minimum load latency: accept c0, req c1 (gnt+rvalid), wb c2. Typical: accept c0, gnt c1, rvalid c2, wb c3.
- Signal hygiene:
  - mem_rvalid is ignored outside REQ/WAIT_R.
  - mem_gnt is ignored outside REQ.
  - wb_valid and misalign are single-cycle pulses.
  - wb_rd and wb_data hold their last value when wb_valid=0.
- ex_rd=0 is handled normally (wb_valid still pulses); the register file discards writes to register 0.
- Reset mid-transaction:
  - Next cycle: IDLE, mem_req=0, pending load dropped, no wb_valid.
  - A late mem_rvalid after reset is ignored.
- ex_valid while ex_ready=0 is not accepted. Upstream holds its op until ex_ready=1.

Test Plan:
- Non-memory ops: reset, then 3 consecutive non-memory ops with ex_addr=5,6,7 and ex_rd=1,2,3 -> wb_valid high 3 consecutive cycles, each one cycle after its accept, with wb_data 5,6,7 and wb_rd 1,2,3; ex_ready stays 1.
- Load with delays: load at ex_addr=0x100, ex_rd=8; mem_gnt after 2 REQ cycles, mem_rvalid 3 cycles later with rdata 0xDEADBEEF -> mem_req=1, mem_we=0, mem_addr=0x100 stable throughout REQ; stall=1 until the writeback cycle; wb_valid pulses once with wb_data=0xDEADBEEF, wb_rd=8; ex_ready=1 on that same cycle.
- Store: ex_addr=0x40, ex_wdata=0x12345678, mem_gnt on the first REQ cycle -> mem_we=1, mem_wdata=0x12345678 for exactly 1 cycle; no wb_valid; IDLE the next cycle.
- Same-cycle grant and response: load with mem_gnt and mem_rvalid both high in the first REQ cycle, rdata 0xA5A5A5A5 -> wb_valid with wb_data=0xA5A5A5A5 exactly 2 cycles after accept; WAIT_R never entered.
- Misaligned load: ex_addr=0x102 -> misalign pulses 1 cycle; mem_req stays 0; no wb_valid; next op accepted the following cycle.
- Reset mid-load: reset asserted while in WAIT_R, then mem_rvalid arrives 1 cycle after reset -> mem_req=0 the cycle after reset; wb_valid stays 0; ex_ready=1.
